// File: rtl/adc_link_pkg.sv
// Shared constants and state types for the serial ADC link (frame length, address field, known
// control words).
package adc_link_pkg;

    localparam int unsigned FRAME_LEN   = 16;
    localparam int unsigned CNT_W       = 5;
    localparam int unsigned ADC_ADDR_HI = 10;

    localparam logic [CNT_W-1:0] CNT_FULL = 5'd16;
    localparam logic [CNT_W-1:0] CNT_LAST = 5'd15;

    localparam logic [FRAME_LEN-1:0] CTRL_CH0 = 16'h6480;
    localparam logic [FRAME_LEN-1:0] CTRL_CH1 = 16'h6680;
    localparam logic [FRAME_LEN-1:0] CTRL_CH2 = 16'h6080;
    localparam logic [FRAME_LEN-1:0] CTRL_CH3 = 16'h6280;

    typedef enum logic [1:0] {RxIdle, RxShift, RxWait} rx_state_e;
    typedef enum logic [1:0] {TxIdle, TxLoad, TxShift} tx_state_e;

endpackage

// File: rtl/adc_link_shifter.sv
// Strobe-driven 16-bit shift register with bit counter; used both as the shift-in receive register
// and as the load/shift-out transmit register.
module adc_link_shifter
    import adc_link_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 clear_i,
    input  logic                 load_i,
    input  logic [FRAME_LEN-1:0] load_data_i,
    input  logic                 shift_i,
    input  logic                 sdata_i,
    output logic [FRAME_LEN-1:0] data_o,
    output logic [CNT_W-1:0]     cnt_o
);

    logic [FRAME_LEN-1:0] sr_q, sr_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    always_comb begin
        sr_d  = sr_q;
        cnt_d = cnt_q;
        if (clear_i) begin
            sr_d  = '0;
            cnt_d = '0;
        end else if (load_i) begin
            sr_d  = load_data_i;
            cnt_d = '0;
        end else if (shift_i) begin
            sr_d  = {sr_q[FRAME_LEN-2:0], sdata_i};
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
        end
    end

    assign data_o = sr_q;
    assign cnt_o  = cnt_q;

endmodule

// File: rtl/adc_serial_responder.sv
// ADC end of the RFS/TFS/SCLK framed link: decodes the channel address from received control words
// and returns {sample, pad, address} conversion words.
module adc_serial_responder
    import adc_link_pkg::*;
#(
    parameter int unsigned SAMPLE_W   = 12,
    parameter int unsigned ADDR_HI    = ADC_ADDR_HI,
    parameter logic [1:0]  RESET_ADDR = 2'b00
) (
    input  logic                 clk_clk,
    input  logic                 reset,
    input  logic                 pe_sclk,
    input  logic                 ne_sclk,
    input  logic                 rfs,
    input  logic                 tfs,
    input  logic                 din,
    output logic                 dout,
    input  logic [SAMPLE_W-1:0]  sample0,
    input  logic [SAMPLE_W-1:0]  sample1,
    input  logic [SAMPLE_W-1:0]  sample2,
    input  logic [SAMPLE_W-1:0]  sample3,
    output logic [FRAME_LEN-1:0] ctrl_word,
    output logic                 ctrl_valid,
    output logic [1:0]           cur_addr,
    output logic                 tx_done,
    output logic [7:0]           short_frames
);

    localparam int unsigned PAD_W = FRAME_LEN - SAMPLE_W - 2;

    rx_state_e rx_state_q, rx_state_d;
    tx_state_e tx_state_q, tx_state_d;

    logic                 rfs_q, tfs_q;
    logic [FRAME_LEN-1:0] ctrl_word_q;
    logic                 ctrl_valid_q;
    logic [1:0]           cur_addr_q;
    logic                 tx_done_q;
    logic [7:0]           short_q, short_d;
    logic [8:0]           short_sum;

    logic                 rx_shift, rx_done, rx_abort;
    logic                 tx_load, tx_shift, tx_done_d, tx_abort, tx_clear;
    logic [FRAME_LEN-1:0] rx_sr, tx_sr, tx_word;
    logic [CNT_W-1:0]     rx_cnt, tx_cnt;
    logic [SAMPLE_W-1:0]  sample_sel;
    logic                 unused_tx_bits;

    // Receive path; frame-sync levels are taken from the registered copy.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_shift   = 1'b0;
        rx_done    = 1'b0;
        rx_abort   = 1'b0;
        case (rx_state_q)
            RxIdle: if (!tfs_q) rx_state_d = RxShift;
            RxShift: begin
                if (rx_cnt == CNT_FULL) begin
                    rx_done    = 1'b1;
                    rx_state_d = RxWait;
                end else if (tfs_q) begin
                    rx_abort   = (rx_cnt != '0);
                    rx_state_d = RxIdle;
                end else if (pe_sclk) begin
                    rx_shift = 1'b1;
                end
            end
            RxWait: if (tfs_q) rx_state_d = RxIdle;
            default: rx_state_d = RxIdle;
        endcase
    end

    // Transmit path; a drop of rfs while bit 0 is on the line still counts as a completed frame.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_load    = 1'b0;
        tx_shift   = 1'b0;
        tx_done_d  = 1'b0;
        tx_abort   = 1'b0;
        case (tx_state_q)
            TxIdle: if (rfs && !rfs_q) tx_state_d = TxLoad;
            TxLoad: begin
                if (!rfs) begin
                    tx_abort   = 1'b1;
                    tx_state_d = TxIdle;
                end else begin
                    tx_load    = 1'b1;
                    tx_state_d = TxShift;
                end
            end
            TxShift: begin
                if (tx_cnt == CNT_LAST && (ne_sclk || !rfs)) begin
                    tx_done_d  = 1'b1;
                    tx_state_d = TxIdle;
                end else if (!rfs) begin
                    tx_abort   = 1'b1;
                    tx_state_d = TxIdle;
                end else if (ne_sclk) begin
                    tx_shift = 1'b1;
                end
            end
            default: tx_state_d = TxIdle;
        endcase
    end

    always_comb begin
        unique case (cur_addr_q)
            2'd0: sample_sel = sample0;
            2'd1: sample_sel = sample1;
            2'd2: sample_sel = sample2;
            2'd3: sample_sel = sample3;
            default: sample_sel = '0;
        endcase
    end

    assign tx_word  = {sample_sel, {PAD_W{1'b0}}, cur_addr_q};
    assign tx_clear = (tx_state_q == TxIdle);

    assign short_sum = {1'b0, short_q} + 9'(rx_abort) + 9'(tx_abort);
    assign short_d   = short_sum[8] ? 8'hFF : short_sum[7:0];

    adc_link_shifter u_rx_shifter (
        .clk_i       (clk_clk),
        .reset_i     (reset),
        .clear_i     (rx_state_q != RxShift),
        .load_i      (1'b0),
        .load_data_i ('0),
        .shift_i     (rx_shift),
        .sdata_i     (din),
        .data_o      (rx_sr),
        .cnt_o       (rx_cnt)
    );

    adc_link_shifter u_tx_shifter (
        .clk_i       (clk_clk),
        .reset_i     (reset),
        .clear_i     (tx_clear),
        .load_i      (tx_load),
        .load_data_i (tx_word),
        .shift_i     (tx_shift),
        .sdata_i     (1'b0),
        .data_o      (tx_sr),
        .cnt_o       (tx_cnt)
    );

    always_ff @(posedge clk_clk) begin
        if (reset) begin
            rx_state_q   <= RxIdle;
            tx_state_q   <= TxIdle;
            rfs_q        <= 1'b0;
            tfs_q        <= 1'b1;
            ctrl_word_q  <= '0;
            ctrl_valid_q <= 1'b0;
            cur_addr_q   <= RESET_ADDR;
            tx_done_q    <= 1'b0;
            short_q      <= '0;
        end else begin
            rx_state_q   <= rx_state_d;
            tx_state_q   <= tx_state_d;
            rfs_q        <= rfs;
            tfs_q        <= tfs;
            ctrl_valid_q <= rx_done;
            tx_done_q    <= tx_done_d;
            short_q      <= short_d;
            if (rx_done) begin
                ctrl_word_q <= rx_sr;
                cur_addr_q  <= rx_sr[ADDR_HI:ADDR_HI-1];
            end
        end
    end

    assign unused_tx_bits = ^tx_sr[FRAME_LEN-2:0];

    assign dout         = (tx_state_q == TxShift) && tx_sr[FRAME_LEN-1];
    assign ctrl_word    = ctrl_word_q;
    assign ctrl_valid   = ctrl_valid_q;
    assign cur_addr     = cur_addr_q;
    assign tx_done      = tx_done_q;
    assign short_frames = short_q;

endmodule
